// File: rtl/decode_pkg.sv
// Shared decode types: op classes, extender selects, decoded entry layout, stage states.
package decode_pkg;

  typedef logic [1:0] op_t;
  localparam op_t OP_DP  = 2'b00;
  localparam op_t OP_MEM = 2'b01;
  localparam op_t OP_BR  = 2'b10;

  typedef enum logic [1:0] {
    IMM_DP8   = 2'b00,
    IMM_MEM12 = 2'b01,
    IMM_BR24  = 2'b10
  } imm_src_t;

  typedef struct packed {
    logic [23:0] imm_field;
    imm_src_t    imm_src;
    logic [3:0]  cond;
    op_t         op;
    logic [5:0]  funct;
    logic        illegal;
  } dec_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } stage_state_t;

endpackage

// File: rtl/decode_imm_stage_op_classifier.sv
// Combinational instruction classifier: splits the word into fields and picks the extender select.
module op_classifier
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output dec_entry_t  entry
);

  // Field split plus op-driven immediate select; op 11 is flagged but still decoded.
  always_comb begin
    entry           = '0;
    entry.imm_field = instr[23:0];
    entry.cond      = instr[31:28];
    entry.op        = instr[27:26];
    entry.funct     = instr[25:20];
    case (instr[27:26])
      OP_DP:   entry.imm_src = IMM_DP8;
      OP_MEM:  entry.imm_src = IMM_MEM12;
      OP_BR:   entry.imm_src = IMM_BR24;
      default: begin
        entry.imm_src = IMM_DP8;
        entry.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_imm_stage.sv
// Registered decode stage feeding the immediate extender, with a 2-entry skid buffer
// so that in_ready comes straight from a flop and throughput holds under backpressure.
module decode_imm_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int IMM_W   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IMM_W-1:0]   out_imm_field,
  output logic [1:0]         out_imm_src,
  output logic [3:0]         out_cond,
  output logic [1:0]         out_op,
  output logic [5:0]         out_funct,
  output logic               out_illegal
);

  if (INSTR_W != 32 || IMM_W != 24) begin : g_param_check
    $error("decode_imm_stage supports only INSTR_W=32 and IMM_W=24");
  end

  stage_state_t state_q, state_d;
  logic         in_ready_q;
  logic         accept, emit, vld_p1;
  logic         load_main, load_skid, skid_to_main;
  dec_entry_t   ent_p0;
  dec_entry_t   main_p1, skid_p1;

  // ---- stage 0: combinational classification of the offered word ----
  op_classifier u_classifier (
    .instr (in_instr),
    .entry (ent_p0)
  );

  assign vld_p1 = (state_q != EMPTY);
  assign accept = in_valid & in_ready_q;
  assign emit   = vld_p1 & out_ready;

  // State and registered in_ready; reset empties the stage immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Next-state and register load selects; flush discards this cycle's accept and emit.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = TWO;
          end
        end
        TWO: if (emit) begin
          skid_to_main = 1'b1;
          state_d      = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- stage 1: main (output) and skid entry registers, written only on transfers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main)         main_p1 <= ent_p0;
      else if (skid_to_main) main_p1 <= skid_p1;
      if (load_skid)         skid_p1 <= ent_p0;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = vld_p1;
  assign out_imm_field = main_p1.imm_field;
  assign out_imm_src   = main_p1.imm_src;
  assign out_cond      = main_p1.cond;
  assign out_op        = main_p1.op;
  assign out_funct     = main_p1.funct;
  assign out_illegal   = main_p1.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage: hand-decoded instruction words, handshake sequences.
module tb_decode_imm_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr;
  logic [23:0] out_imm_field;
  logic [1:0]  out_imm_src, out_op;
  logic [3:0]  out_cond;
  logic [5:0]  out_funct;

  int n_cmp = 0;
  int n_bad = 0;

  // {valid, imm_field, imm_src, cond, op, funct, illegal}
  localparam logic [39:0] E_MOV = {1'b1, 24'hA01005, 2'b00, 4'hE, 2'b00, 6'h3A, 1'b0};
  localparam logic [39:0] E_LDR = {1'b1, 24'h912004, 2'b01, 4'hE, 2'b01, 6'h19, 1'b0};
  localparam logic [39:0] E_B   = {1'b1, 24'hFFFFFE, 2'b10, 4'hE, 2'b10, 6'h2F, 1'b0};
  localparam logic [39:0] E_ILL = {1'b1, 24'h000000, 2'b00, 4'h1, 2'b11, 6'h00, 1'b1};
  localparam logic [39:0] E_ZERO = 40'h0;

  localparam logic [31:0] W_MOV = 32'hE3A01005;
  localparam logic [31:0] W_LDR = 32'hE5912004;
  localparam logic [31:0] W_B   = 32'hEAFFFFFE;
  localparam logic [31:0] W_ILL = 32'h1C000000;

  wire [39:0] obs = {out_valid, out_imm_field, out_imm_src, out_cond, out_op, out_funct, out_illegal};

  decode_imm_stage #(.INSTR_W(32), .IMM_W(24)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_imm_field (out_imm_field),
    .out_imm_src   (out_imm_src),
    .out_cond      (out_cond),
    .out_op        (out_op),
    .out_funct     (out_funct),
    .out_illegal   (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
    #12;
    n_cmp++; if (obs !== E_ZERO) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, E_ZERO); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b1;
    step();
    n_cmp++; if (obs !== E_ZERO) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, E_ZERO); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instr = W_MOV; out_ready = 1'b1;
    step();
    n_cmp++; if (obs !== E_MOV) begin n_bad++; $display("FAIL single_mov: got %h want %h", obs, E_MOV); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", in_ready); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = W_LDR; out_ready = 1'b1;
    step();
    n_cmp++; if (obs !== E_LDR) begin n_bad++; $display("FAIL b2b_first: got %h want %h", obs, E_LDR); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
    in_instr = W_B;
    step();
    n_cmp++; if (obs !== E_B) begin n_bad++; $display("FAIL b2b_second: got %h want %h", obs, E_B); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready2: got %b want 1", in_ready); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = W_MOV;
    step();
    n_cmp++; if (obs !== E_MOV) begin n_bad++; $display("FAIL bp_one: got %h want %h", obs, E_MOV); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_one_ready: got %b want 1", in_ready); end
    in_instr = W_LDR;
    step();
    n_cmp++; if (obs !== E_MOV) begin n_bad++; $display("FAIL bp_two_hold: got %h want %h", obs, E_MOV); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_two_ready: got %b want 0", in_ready); end
    in_instr = W_B;
    step();
    n_cmp++; if (obs !== E_MOV) begin n_bad++; $display("FAIL bp_stable: got %h want %h", obs, E_MOV); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stable_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (obs !== E_LDR) begin n_bad++; $display("FAIL bp_drain_ldr: got %h want %h", obs, E_LDR); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_drain_ready: got %b want 1", in_ready); end
    step();
    n_cmp++; if (obs !== E_B) begin n_bad++; $display("FAIL bp_drain_b: got %h want %h", obs, E_B); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_instr = W_ILL; out_ready = 1'b0;
    step();
    n_cmp++; if (obs !== E_ILL) begin n_bad++; $display("FAIL illegal_entry: got %h want %h", obs, E_ILL); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = W_MOV;
    step();
    in_instr = W_LDR;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_setup_two: got %b want 0", in_ready); end
    in_instr = W_B; flush = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_nothing_left: got %b want 0", out_valid); end
    in_valid = 1'b1; in_instr = W_ILL;
    step();
    n_cmp++; if (obs !== E_ILL) begin n_bad++; $display("FAIL flush_next_word: got %h want %h", obs, E_ILL); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = W_LDR;
    step();
    n_cmp++; if (obs !== E_LDR) begin n_bad++; $display("FAIL areset_setup: got %h want %h", obs, E_LDR); end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (obs !== E_ZERO) begin n_bad++; $display("FAIL areset_outputs: got %h want %h", obs, E_ZERO); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready: got %b want 1", in_ready); end
    #2 reset = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_idle: got %b want 0", out_valid); end
    in_valid = 1'b1; in_instr = W_B; out_ready = 1'b1;
    step();
    n_cmp++; if (obs !== E_B) begin n_bad++; $display("FAIL areset_first: got %h want %h", obs, E_B); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
